// File: rtl/dma_packet_sender_arb.sv
// Serialises read-request, tile-write and end-of-program packets into an
// MSB-first byte stream, arbitrating between three FWFT send queues.
module dma_packet_sender_arb #(
    parameter int ADDR_BYTES       = 2,
    parameter int TILE_BYTES       = 36,
    parameter int TAG_BYTES        = 2,
    parameter int ARB_RR           = 0,
    parameter int END_AFTER_WRITES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      o_tx_valid,
    output logic [7:0]                o_tx_data,
    input  logic                      i_tx_ready,
    input  logic [8*ADDR_BYTES-1:0]   i_rd_data,
    input  logic                      i_rd_avail,
    output logic                      o_rd_re,
    input  logic [8*ADDR_BYTES-1:0]   i_wr_addr,
    input  logic [8*TILE_BYTES-1:0]   i_wr_data,
    input  logic                      i_wr_avail,
    output logic                      o_wr_re,
    input  logic [8*TAG_BYTES-1:0]    i_end_tag,
    input  logic                      i_end_avail,
    output logic                      o_end_re,
    output logic                      o_busy,
    output logic                      o_pkt_done,
    output logic                      o_state
);

    localparam int RD_LEN  = 1 + ADDR_BYTES;
    localparam int WR_LEN  = 1 + ADDR_BYTES + TILE_BYTES;
    localparam int END_LEN = 1 + TAG_BYTES;
    localparam int MAX_LEN = (WR_LEN > END_LEN) ? WR_LEN : END_LEN;
    localparam int SR_W    = 8 * MAX_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
    typedef enum logic [1:0] {CH_RD = 2'd0, CH_WR = 2'd1, CH_END = 2'd2} chan_t;

    state_t            r_state;
    state_t            w_state_next;
    chan_t             r_ptr;
    chan_t             w_start;
    chan_t             w_sel;
    chan_t             w_ptr_next;
    logic [SR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SR_W-1:0]   w_load;
    logic [CNT_W-1:0]  w_len;
    logic [2:0]        w_elig;
    logic              w_grant;
    logic              w_take;
    logic              w_done;
    logic              w_shift;

    // End-of-program may be held back so it never overtakes queued writes.
    always_comb begin
        w_elig  = {i_end_avail && !((END_AFTER_WRITES != 0) && i_wr_avail),
                   i_wr_avail, i_rd_avail};
        w_grant = |w_elig;
        w_start = (ARB_RR != 0) ? r_ptr : CH_RD;
        w_sel   = CH_RD;
        case (w_start)
            CH_WR: begin
                if (w_elig[1])      w_sel = CH_WR;
                else if (w_elig[2]) w_sel = CH_END;
                else                w_sel = CH_RD;
            end
            CH_END: begin
                if (w_elig[2])      w_sel = CH_END;
                else if (w_elig[0]) w_sel = CH_RD;
                else                w_sel = CH_WR;
            end
            default: begin
                if (w_elig[0])      w_sel = CH_RD;
                else if (w_elig[1]) w_sel = CH_WR;
                else                w_sel = CH_END;
            end
        endcase
        case (w_sel)
            CH_RD:   w_ptr_next = CH_WR;
            CH_WR:   w_ptr_next = CH_END;
            default: w_ptr_next = CH_RD;
        endcase
    end

    // Packet image is left-aligned so the header always sits in the top byte.
    always_comb begin
        w_load = '0;
        w_len  = '0;
        case (w_sel)
            CH_WR: begin
                w_load[SR_W-1 -: 8*WR_LEN] = {8'h03, i_wr_addr, i_wr_data};
                w_len = CNT_W'(WR_LEN);
            end
            CH_END: begin
                w_load[SR_W-1 -: 8*END_LEN] = {8'h04, i_end_tag};
                w_len = CNT_W'(END_LEN);
            end
            default: begin
                w_load[SR_W-1 -: 8*RD_LEN] = {8'h02, i_rd_data};
                w_len = CNT_W'(RD_LEN);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_done       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_take       = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Nothing is popped or presented while reset is held.
        if (reset) begin
            w_take  = 1'b0;
            w_done  = 1'b0;
            w_shift = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= CH_RD;
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_ptr <= w_ptr_next;
            r_sr  <= w_load;
            r_cnt <= w_len;
        end else if (w_shift) begin
            r_sr  <= r_sr << 8;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tx_valid = (r_state == S_SEND) && !reset;
    assign o_busy     = (r_state == S_SEND) && !reset;
    assign o_tx_data  = r_sr[SR_W-1 -: 8];
    assign o_rd_re    = w_take && (w_sel == CH_RD);
    assign o_wr_re    = w_take && (w_sel == CH_WR);
    assign o_end_re   = w_take && (w_sel == CH_END);
    assign o_pkt_done = w_done;
    assign o_state    = r_state;

endmodule

// File: tb/tb_dma_packet_sender_arb.sv
// Directed bench for dma_packet_sender_arb: default build, a round-robin
// 4-byte-address build and a round-robin build with end-after-writes.
module tb_dma_packet_sender_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       tx_valid [3];
    logic [7:0] tx_data  [3];
    logic       tx_ready [3];
    logic       rd_avail [3];
    logic       wr_avail [3];
    logic       end_avail[3];
    logic       rd_re    [3];
    logic       wr_re    [3];
    logic       end_re   [3];
    logic       busy     [3];
    logic       pkt_done [3];
    logic       state    [3];

    logic [15:0]  a_rd_data, a_wr_addr, a_end_tag;
    logic [287:0] a_wr_data;
    logic [31:0]  b_rd_data, b_wr_addr, b_wr_data;
    logic [15:0]  b_end_tag;
    logic [7:0]   c_rd_data, c_wr_addr, c_end_tag;
    logic [15:0]  c_wr_data;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_packet_sender_arb #(.ADDR_BYTES(2), .TILE_BYTES(36), .TAG_BYTES(2),
                            .ARB_RR(0), .END_AFTER_WRITES(1)) u_a (
        .clk(clk), .reset(reset),
        .o_tx_valid(tx_valid[0]), .o_tx_data(tx_data[0]), .i_tx_ready(tx_ready[0]),
        .i_rd_data(a_rd_data), .i_rd_avail(rd_avail[0]), .o_rd_re(rd_re[0]),
        .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .i_wr_avail(wr_avail[0]), .o_wr_re(wr_re[0]),
        .i_end_tag(a_end_tag), .i_end_avail(end_avail[0]), .o_end_re(end_re[0]),
        .o_busy(busy[0]), .o_pkt_done(pkt_done[0]), .o_state(state[0]));

    dma_packet_sender_arb #(.ADDR_BYTES(4), .TILE_BYTES(4), .TAG_BYTES(2),
                            .ARB_RR(1), .END_AFTER_WRITES(0)) u_b (
        .clk(clk), .reset(reset),
        .o_tx_valid(tx_valid[1]), .o_tx_data(tx_data[1]), .i_tx_ready(tx_ready[1]),
        .i_rd_data(b_rd_data), .i_rd_avail(rd_avail[1]), .o_rd_re(rd_re[1]),
        .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_wr_avail(wr_avail[1]), .o_wr_re(wr_re[1]),
        .i_end_tag(b_end_tag), .i_end_avail(end_avail[1]), .o_end_re(end_re[1]),
        .o_busy(busy[1]), .o_pkt_done(pkt_done[1]), .o_state(state[1]));

    dma_packet_sender_arb #(.ADDR_BYTES(1), .TILE_BYTES(2), .TAG_BYTES(1),
                            .ARB_RR(1), .END_AFTER_WRITES(1)) u_c (
        .clk(clk), .reset(reset),
        .o_tx_valid(tx_valid[2]), .o_tx_data(tx_data[2]), .i_tx_ready(tx_ready[2]),
        .i_rd_data(c_rd_data), .i_rd_avail(rd_avail[2]), .o_rd_re(rd_re[2]),
        .i_wr_addr(c_wr_addr), .i_wr_data(c_wr_data), .i_wr_avail(wr_avail[2]), .o_wr_re(wr_re[2]),
        .i_end_tag(c_end_tag), .i_end_avail(end_avail[2]), .o_end_re(end_re[2]),
        .o_busy(busy[2]), .o_pkt_done(pkt_done[2]), .o_state(state[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_field(input logic [31:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(v[8*(nbytes-1-i) +: 8]);
    endtask

    // Called just after a negedge; checks an IDLE cycle and its pop pattern {end,wr,rd}.
    task automatic at_idle(input int d, input logic [2:0] exp_re, input string tag);
        #1;
        check({tag, " valid"}, tx_valid[d], 0);
        check({tag, " busy"}, busy[d], 0);
        check({tag, " done"}, pkt_done[d], 0);
        check({tag, " re"}, {end_re[d], wr_re[d], rd_re[d]}, exp_re);
    endtask

    // Called at the negedge after a grant; consumes exp_q byte by byte.
    task automatic recv(input int d, input bit toggle, input string tag);
        int cyc = 0;
        bit held_v = 0;
        logic [7:0] held, e;
        tx_ready[d] = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            #1;
            if (cyc == 0) check({tag, " latency"}, tx_valid[d], 1);
            check({tag, " no pop"}, {end_re[d], wr_re[d], rd_re[d]}, 0);
            if (tx_valid[d]) begin
                if (held_v) check({tag, " stall stable"}, tx_data[d], held);
                if (tx_ready[d]) begin
                    e = exp_q.pop_front();
                    check({tag, " byte"}, tx_data[d], e);
                    check({tag, " pkt_done"}, pkt_done[d], (exp_q.size() == 0));
                    held_v = 0;
                end else begin
                    held   = tx_data[d];
                    held_v = 1;
                end
            end
            @(negedge clk);
            cyc++;
            if (toggle) tx_ready[d] = ~tx_ready[d];
        end
        if (exp_q.size() != 0) begin
            check({tag, " timeout bytes left"}, exp_q.size(), 0);
            exp_q.delete();
        end
        tx_ready[d] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            tx_ready[d] = 1'b0; rd_avail[d] = 1'b0; wr_avail[d] = 1'b0; end_avail[d] = 1'b0;
        end
        a_rd_data = '0; a_wr_addr = '0; a_end_tag = '0; a_wr_data = '0;
        b_rd_data = 32'hDEADBEEF; b_wr_addr = 32'h01020304; b_wr_data = 32'hA0B1C2D3; b_end_tag = 16'h5A5A;
        c_rd_data = 8'h00; c_wr_addr = 8'h44; c_wr_data = 16'h5566; c_end_tag = 8'h77;
        for (int j = 0; j < 36; j++) a_wr_data[287-8*j -: 8] = 8'(j);

        // Reset state of all three builds
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset valid", tx_valid[d], 0);
            check("reset data", tx_data[d], 0);
            check("reset busy", busy[d], 0);
            check("reset done", pkt_done[d], 0);
            check("reset state", state[d], 0);
            check("reset re", {end_re[d], wr_re[d], rd_re[d]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Single read request
        @(negedge clk);
        rd_avail[0] = 1'b1; a_rd_data = 16'hA5C3; tx_ready[0] = 1'b1;
        at_idle(0, 3'b001, "rd grant");
        @(negedge clk);
        rd_avail[0] = 1'b0;
        exp_q.push_back(8'h02); exp_q.push_back(8'hA5); exp_q.push_back(8'hC3);
        recv(0, 0, "rd");
        at_idle(0, 3'b000, "rd after");

        // Write with toggling ready
        @(negedge clk);
        wr_avail[0] = 1'b1; a_wr_addr = 16'h0010;
        at_idle(0, 3'b010, "wr grant");
        @(negedge clk);
        wr_avail[0] = 1'b0;
        exp_q.push_back(8'h03); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
        for (int j = 0; j < 36; j++) exp_q.push_back(8'(j));
        recv(0, 1, "wr toggle");
        at_idle(0, 3'b000, "wr after");

        // Fixed priority with all three pending
        @(negedge clk);
        rd_avail[0] = 1'b1; a_rd_data = 16'h1111;
        wr_avail[0] = 1'b1; a_wr_addr = 16'h0020;
        end_avail[0] = 1'b1; a_end_tag = 16'h0007;
        at_idle(0, 3'b001, "fp read first");
        @(negedge clk);
        rd_avail[0] = 1'b0;
        exp_q.push_back(8'h02); exp_q.push_back(8'h11); exp_q.push_back(8'h11);
        recv(0, 0, "fp rd");
        at_idle(0, 3'b010, "fp write second");
        @(negedge clk);
        wr_avail[0] = 1'b0;
        exp_q.push_back(8'h03); exp_q.push_back(8'h00); exp_q.push_back(8'h20);
        for (int j = 0; j < 36; j++) exp_q.push_back(8'(j));
        recv(0, 0, "fp wr");
        at_idle(0, 3'b100, "fp end third");
        @(negedge clk);
        end_avail[0] = 1'b0;
        exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h07);
        recv(0, 0, "fp end");
        at_idle(0, 3'b000, "fp after");

        // Round-robin rotation, 4-byte address / 4-byte tile build
        @(negedge clk);
        rd_avail[1] = 1'b1; wr_avail[1] = 1'b1; end_avail[1] = 1'b1;
        at_idle(1, 3'b001, "rr grant R");
        @(negedge clk);
        push_field(32'h02DEADBE, 4); exp_q.push_back(8'hEF);
        recv(1, 0, "rr rd");
        at_idle(1, 3'b010, "rr grant W");
        @(negedge clk);
        push_field(32'h03010203, 4); push_field(32'h04A0B1C2, 4); exp_q.push_back(8'hD3);
        recv(1, 0, "rr wr9");
        at_idle(1, 3'b100, "rr grant E");
        @(negedge clk);
        push_field(32'h00045A5A, 3);
        recv(1, 0, "rr end");
        at_idle(1, 3'b001, "rr grant R again");
        @(negedge clk);
        rd_avail[1] = 1'b0; wr_avail[1] = 1'b0; end_avail[1] = 1'b0;
        push_field(32'h02DEADBE, 4); exp_q.push_back(8'hEF);
        recv(1, 0, "rr rd2");
        at_idle(1, 3'b000, "rr after");

        // Round-robin pointer at END, but end held back by pending writes
        @(negedge clk);
        wr_avail[2] = 1'b1;
        at_idle(2, 3'b010, "eaw w1 grant");
        @(negedge clk);
        end_avail[2] = 1'b1;
        push_field(32'h03445566, 4);
        recv(2, 0, "eaw w1");
        at_idle(2, 3'b010, "eaw w2 grant");
        @(negedge clk);
        wr_avail[2] = 1'b0;
        push_field(32'h03445566, 4);
        recv(2, 0, "eaw w2");
        at_idle(2, 3'b100, "eaw end grant");
        @(negedge clk);
        end_avail[2] = 1'b0;
        exp_q.push_back(8'h04); exp_q.push_back(8'h77);
        recv(2, 0, "eaw end");
        at_idle(2, 3'b000, "eaw after");

        // Reset in the middle of a write, then a queued read goes out cleanly
        @(negedge clk);
        wr_avail[0] = 1'b1; a_wr_addr = 16'h0010;
        at_idle(0, 3'b010, "abort wr grant");
        @(negedge clk);
        wr_avail[0] = 1'b0; rd_avail[0] = 1'b1; a_rd_data = 16'h1234; tx_ready[0] = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            #1;
            if (k == 0)      check("abort byte", tx_data[0], 8'h03);
            else if (k == 1) check("abort byte", tx_data[0], 8'h00);
            else if (k == 2) check("abort byte", tx_data[0], 8'h10);
            else             check("abort byte", tx_data[0], 32'(k - 3));
            if (k < 10) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort valid", tx_valid[0], 0);
        check("abort busy", busy[0], 0);
        check("abort no pop", {end_re[0], wr_re[0], rd_re[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        at_idle(0, 3'b001, "abort rd grant");
        @(negedge clk);
        rd_avail[0] = 1'b0;
        exp_q.push_back(8'h02); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        recv(0, 0, "abort rd");
        at_idle(0, 3'b000, "abort after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_packet_sender_arb.md
Name: dma_packet_sender_arb

Overview:
- Parametrised successor to the DMA packet sender. Serialises host-bound DMA packets (read request, tile write, end-of-program notification) into a byte stream with a valid/ready handshake.
- Width, address size, tile size and tag size are parametrised. Arbitration is fixed-priority or round-robin.
- Optional ordering rule holds end-of-program until the write queue has drained.
- Sits between the DMA send queues and the link layer (UART today, wider link later).

Parameters:
ADDR_BYTES, 2, host address bytes in read/write packets (1..4)
TILE_BYTES, 36, payload bytes per write packet (1..255)
TAG_BYTES, 2, execution-tag bytes in end-program packet (1..4)
ARB_RR, 0, 0 = fixed priority read>write>end; 1 = round-robin
END_AFTER_WRITES, 1, 1 = end-program not granted while wr_avail is high

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tx_valid  out  1  byte valid toward link
tx_data  out  8  byte to link, MSB-first serialisation
tx_ready  in  1  link accepts byte when tx_valid&&tx_ready
rd_data  in  8*ADDR_BYTES  read-request host address (FWFT queue head)
rd_avail  in  1  read queue non-empty
rd_re  out  1  read-queue pop, 1-cycle pulse
wr_addr  in  8*ADDR_BYTES  write host address (FWFT head)
wr_data  in  8*TILE_BYTES  write tile, byte 0 = bits [MSB -: 8]
wr_avail  in  1  write queue non-empty
wr_re  out  1  write-queue pop pulse
end_tag  in  8*TAG_BYTES  execution tag (FWFT head)
end_avail  in  1  end queue non-empty
end_re  out  1  end-queue pop pulse
busy  out  1  high while a packet is in flight (state != IDLE)
pkt_done  out  1  1-cycle pulse on acceptance of a packet's last byte

Behaviour:
- Reset values: tx_valid=0, tx_data=0, rd_re=wr_re=end_re=0, busy=0, pkt_done=0, state=IDLE, rr pointer=READ.
- Reset mid-packet aborts: no further bytes are sent and the packet is not retried. The queue entry was already popped.
- States: IDLE -> SEND -> IDLE.
- IDLE (tx_valid low):
  - Evaluate eligible requests: rd_avail, wr_avail, and end_avail && !(END_AFTER_WRITES && wr_avail).
  - On a grant, pulse the corresponding re for exactly one cycle.
  - In the same edge, load the shift register with {header, addr/tag, payload}, load byte count, go to SEND.
  - Head data is sampled on the grant cycle; the queue is FWFT.
- Fixed priority: read > write > end.
- RR: search order starts at the channel after the last granted (READ->WRITE->END->READ); pointer updates only on grant.
- Packet formats (header byte, then fields MSB-first):
  - READ: 0x02, address; length 1+ADDR_BYTES.
  - WRITE: 0x03, address, TILE_BYTES tile bytes; length 1+ADDR_BYTES+TILE_BYTES.
  - END: 0x04, tag; length 1+TAG_BYTES.
- SEND:
  - tx_valid=1 with the current byte from the cycle after the grant.
  - On tx_valid&&tx_ready: shift 8, decrement count.
  - tx_data/tx_valid stay stable while tx_ready is low.
  - Last byte accepted: pkt_done=1 for one cycle, tx_valid=0, return to IDLE.
  - Next grant no earlier than that IDLE cycle, so there is 1 bubble between packets. Minimum latency grant->header = 1 cycle.
- Throughput: with tx_ready held high, 1 byte per cycle inside a packet.
- Byte counter width is clog2(max packet length + 1). No wrap-around inside a packet.
- Simultaneous requests are resolved by the active arbitration rule. Requests arriving during SEND wait; none are dropped.
- With END_AFTER_WRITES=1 and continuous writes, END waits indefinitely. This is documented and intentional.

Test Plan:
- Reset, then rd_avail=1, rd_data=16'hA5C3, tx_ready=1 -> rd_re pulse 1 cycle; bytes 02,A5,C3 on consecutive cycles; pkt_done with C3; busy low after.
- wr_addr=16'h0010, wr_data bytes 00..23, tx_ready toggling 1/0 -> 39 bytes 03,00,10,00,01..23 in order; tx_data stable on stall cycles; single wr_re.
- rd, wr, end all asserted, ARB_RR=0 -> order READ, WRITE, END (END only after wr_avail drops). With ARB_RR=1 and all held high, END_AFTER_WRITES=0 -> grants rotate R,W,E,R.
- end_avail=1, end_tag=16'h0007, wr_avail=1, END_AFTER_WRITES=1 -> write packet first; END (04,00,07) only after wr_avail=0.
- Reset asserted at byte 10 of a write -> next cycle tx_valid=0, busy=0; after release, the next queued read request is sent cleanly.
- TILE_BYTES=4, ADDR_BYTES=4 build -> write packet length 9, bytes MSB-first; pkt_done timing correct.
